// File: rtl/activ4_stim_tx.sv
// Serial stimulus transmitter for the activity-4 Moore FSMs: resets the FSM under test,
// shifts a pattern out LSB-first on x and collects the returned y bits into resp.
module activ4_stim_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    output logic             x,
    output logic             x_valid,
    output logic             dut_reset,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resp
);

    typedef enum logic [2:0] {IDLE, RST, SHIFT, DRAIN, DONE} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    state_t           state;
    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] pat_next;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;

    // pat is consumed as a shift register, so the next bit is always pat_next[0]
    assign pat_next = pat >> 1;

    // y for bit i arrives one cycle after bit i, so capture lags the shift by one (cnt-1)
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            x           <= 1'b0;
            x_valid     <= 1'b0;
            dut_reset   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            resp        <= '0;
            pat         <= '0;
            len         <= '0;
            cnt         <= '0;
        end else begin
            done      <= 1'b0;
            dut_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        pat         <= pattern;
                        len         <= (length > MAX_LEN) ? MAX_LEN : length;
                        resp        <= '0;
                        cnt         <= '0;
                        dut_reset   <= 1'b1;
                        busy        <= 1'b1;
                        start_ready <= 1'b0;
                        state       <= RST;
                    end
                end
                RST: begin
                    if (len == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        x       <= pat[0];
                        x_valid <= 1'b1;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        resp <= resp | (WIDTH'(y_in) << (cnt - ONE));
                    end
                    if (cnt == len - ONE) begin
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        x   <= pat_next[0];
                        pat <= pat_next;
                        cnt <= cnt + ONE;
                    end
                end
                DRAIN: begin
                    resp  <= resp | (WIDTH'(y_in) << cnt);
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    cnt         <= '0;
                    state       <= IDLE;
                end
                default: begin
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    x           <= 1'b0;
                    x_valid     <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/activ4_stim_tx.md
Name: activ4_stim_tx

Overview:
- Serial stimulus transmitter for the activity-4 single-input Moore FSMs (8-state original and reduced variants).
- Accepts a parallel bit pattern over a valid/ready handshake and pulses a synchronous reset to the FSM under test.
- Shifts the pattern out LSB-first on the FSM's serial input `x`, one bit per clock.
- Captures the FSM's Moore output `y` for every bit into a response word, so two equivalent machines can be compared on identical stimulus.

Parameters:
- WIDTH, 8, maximum pattern length in bits.
- LEN_W, $clog2(WIDTH+1), width of the length field.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_valid  input  1  request to send a pattern.
- start_ready  output  1  block idle and able to accept a pattern.
- pattern  input  WIDTH  bits to send; bit 0 is sent first.
- length  input  LEN_W  number of bits to send, 0..WIDTH.
- x  output  1  serial bit to the FSM under test.
- x_valid  output  1  high while `x` carries a pattern bit.
- dut_reset  output  1  one-cycle reset pulse to the FSM under test.
- y_in  input  1  Moore output returned by the FSM under test.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse; `resp` is complete.
- resp  output  WIDTH  captured `y` per bit; bit i is the response to pattern bit i.

Behaviour:
- Reset values: state = IDLE, start_ready = 1. All other outputs are 0: x, x_valid, dut_reset, busy, done, resp. Internal counters are 0.
- Reset has priority over all other inputs. Asserting it mid-operation aborts the transfer, returns to IDLE, and clears `resp` next cycle. No `done` pulse is produced for an aborted transfer.
- Handshake: the pattern is accepted in a cycle where start_valid && start_ready.
  - On accept, register `pattern` and `length`, and clear `resp`.
  - A length value greater than WIDTH is clamped to WIDTH.
  - start_valid is ignored while busy; no queueing.
- States and cycle timing, with T = accept cycle and L = clamped length:
  - IDLE: start_ready = 1. Go to RST on accept.
  - RST (cycle T+1): dut_reset = 1, x_valid = 0. If L = 0, go to DONE. Otherwise go to SHIFT.
  - SHIFT (cycles T+2 .. T+1+L): x = pattern[i] and x_valid = 1, where i = bit index 0..L-1. After bit L-1, go to DRAIN.
  - DRAIN (cycle T+2+L): x_valid = 0, x = 0. Go to DONE.
  - DONE (cycle T+3+L, or T+2 when L = 0): done = 1, busy = 1, start_ready = 0. Go to IDLE.
- Response capture: the FSM updates on the edge that ends bit i's cycle, so `y` for bit i is valid during the following cycle.
  - y_in is sampled at the end of the cycle after bit i was driven, into resp[i], for i = 0..L-1.
  - Bit 0 is sampled at the end of cycle T+3 and bit L-1 at the end of cycle T+2+L (DRAIN).
  - y_in is never sampled in IDLE, RST or DONE.
- resp[WIDTH-1:L] remain 0.
- resp holds its value after DONE until the next accept or reset.
- x is 0 whenever x_valid = 0.
- Bit counter width is LEN_W. The counter does not wrap, because L ≤ WIDTH.
- Back-to-back: the earliest next accept is the IDLE cycle after DONE.

Test Plan:
- Reset values: assert reset 2 cycles -> start_ready = 1; x, x_valid, dut_reset, busy, done all 0; resp = 0x00.
- Loopback timing: pattern = 0xB5, length = 8, y_in = x registered one cycle -> check all of the following:
  - dut_reset high in cycle T+1 only.
  - x sequence 1,0,1,0,1,1,0,1 in cycles T+2..T+9.
  - done in cycle T+11.
  - resp = 0xB5.
- Short pattern: pattern = 0xFF, length = 3, y_in tied 1 -> resp = 0x07, done in cycle T+6, x_valid high exactly 3 cycles.
- Zero length and clamping:
  - length = 0 -> dut_reset in cycle T+1, done in cycle T+2, resp = 0x00, x_valid never high.
  - length = 12 -> treated as 8, so done in cycle T+11.
- Busy protection and mid-operation reset:
  - start_valid held high with new pattern 0x0F during SHIFT -> ignored; the first transfer completes unchanged.
  - reset asserted at bit 4 -> IDLE next cycle, resp = 0, no done pulse.
- Back-to-back transfers: start_valid held high continuously -> second accept occurs in the IDLE cycle after DONE, and resp clears on that accept.
